pll_lock_sequencer: RTL and testbench

- Consumer end of the core PLL interface. Runs on the PLL's 48 MHz output and takes the PLL `locked` flag.
- Produces a clean, synchronised system reset and phase-aligned 12/6/3 MHz clock-enable strobes for the game logic.
- Tracks lock-loss events and re-sequences the core whenever lock drops.
- Sits between the PLL wrapper and the core top level.

---
 rtl/pll_lock_sequencer_if.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 117 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Core PLL handshake: lock flag and loss-clear in, core reset/ready/strobes and loss status out.
interface pll_lock_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             locked;
   logic             clr_lost;
   logic             sys_reset;
   logic             ready;
   logic             ce_12m;
   logic             ce_6m;
   logic             ce_3m;
   logic             lock_lost;
   logic [CNT_W-1:0] loss_count;

   modport master (
      output locked, clr_lost,
      input  sys_reset, ready, ce_12m, ce_6m, ce_3m, lock_lost, loss_count
   );

   modport slave (
      input  locked, clr_lost,
      output sys_reset, ready, ce_12m, ce_6m, ce_3m, lock_lost, loss_count
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Waits for a stable PLL lock, holds the core in reset, then releases it with 12/6/3 MHz enables.
//
// state     | meaning
// WAIT_LOCK | synchronised lock low, core held in reset
// STABILIZE | counting consecutive locked cycles
// HOLD      | lock confirmed, keeping sys_reset asserted for RESET_CYCLES
// RUN       | core released, divider running, strobes active
module pll_lock_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int RESET_CYCLES  = 16,
   parameter int CNT_W         = 8
) (
   input logic                 clk,
   input logic                 rst,
   pll_lock_sequencer_if.slave pll
);
   localparam int CNT_MAX = (STABLE_CYCLES > RESET_CYCLES) ? STABLE_CYCLES : RESET_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD, RUN} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic [CW-1:0]          cnt;
   logic [3:0]             div;
   logic                   sys_reset_r;
   logic                   ready_r;
   logic                   ce_12m_r;
   logic                   ce_6m_r;
   logic                   ce_3m_r;
   logic                   lock_lost_r;
   logic [CNT_W-1:0]       loss_count_r;

   assign lock_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], pll.locked};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         div          <= '0;
         sys_reset_r  <= 1'b1;
         ready_r      <= 1'b0;
         ce_12m_r     <= 1'b0;
         ce_6m_r      <= 1'b0;
         ce_3m_r      <= 1'b0;
         lock_lost_r  <= 1'b0;
         loss_count_r <= '0;
      end else begin
         ce_12m_r <= 1'b0;
         ce_6m_r  <= 1'b0;
         ce_3m_r  <= 1'b0;
         div      <= '0;
         if (pll.clr_lost) begin
            lock_lost_r  <= 1'b0;
            loss_count_r <= '0;
         end
         if (state != WAIT_LOCK && !lock_s) begin
            // a loss in the clear cycle counts as the first event after the clear
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_reset_r <= 1'b1;
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b1;
            if (pll.clr_lost)          loss_count_r <= CNT_W'(1);
            else if (loss_count_r != '1) loss_count_r <= loss_count_r + CNT_W'(1);
         end else begin
            case (state)
               WAIT_LOCK: begin
                  cnt <= '0;
                  if (lock_s) state <= STABILIZE;
               end
               STABILIZE: begin
                  if (cnt == CW'(STABLE_CYCLES - 1)) begin
                     state <= HOLD;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               HOLD: begin
                  if (cnt == CW'(RESET_CYCLES - 1)) begin
                     state       <= RUN;
                     cnt         <= '0;
                     sys_reset_r <= 1'b0;
                     ready_r     <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               RUN: begin
                  // strobes are registered, so decode the value div is about to take
                  div      <= div + 4'd1;
                  ce_12m_r <= (div[1:0] == 2'd2);
                  ce_6m_r  <= (div[2:0] == 3'd6);
                  ce_3m_r  <= (div == 4'd14);
               end
               default: state <= WAIT_LOCK;
            endcase
         end
      end
   end

   assign pll.sys_reset  = sys_reset_r;
   assign pll.ready      = ready_r;
   assign pll.ce_12m     = ce_12m_r;
   assign pll.ce_6m      = ce_6m_r;
   assign pll.ce_3m      = ce_3m_r;
   assign pll.lock_lost  = lock_lost_r;
   assign pll.loss_count = loss_count_r;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed sequencing scenarios plus randomized lock traffic vs a progress model.
module tb_pll_lock_sequencer;
   localparam int SS   = 2;
   localparam int ST   = 8;
   localparam int RT   = 4;
   localparam int CW   = 2;
   localparam int FULL = 1 + ST + RT;
   localparam int LAT  = SS + 1 + ST + RT;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   pll_lock_sequencer_if #(.CNT_W(CW)) bus ();

   pll_lock_sequencer #(
      .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .RESET_CYCLES(RT), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll(bus.slave)
   );

   always #5 clk = ~clk;

   // Model: m_p counts consecutive synchronised-locked clocks since the last drop.
   logic [SS-1:0] h;
   int            m_p;
   logic          m_lost;
   int            m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0; m_p <= 0; m_lost <= 1'b0; m_cnt <= 0;
      end else begin
         h   <= {h[SS-2:0], bus.locked};
         m_p <= h[SS-1] ? m_p + 1 : 0;
         if (!h[SS-1] && m_p > 0) begin
            m_lost <= 1'b1;
            m_cnt  <= bus.clr_lost ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
         end else if (bus.clr_lost) begin
            m_lost <= 1'b0;
            m_cnt  <= 0;
         end
      end
   end

   function automatic logic [7:0] exp_vec();
      logic rdy;
      int   k;
      rdy = (m_p >= FULL);
      k   = m_p - FULL + 1;
      return {!rdy, rdy, rdy && (k % 4 == 0), rdy && (k % 8 == 0), rdy && (k % 16 == 0),
              m_lost, CW'(m_cnt)};
   endfunction

   function automatic logic [7:0] obs_vec();
      return {bus.sys_reset, bus.ready, bus.ce_12m, bus.ce_6m, bus.ce_3m,
              bus.lock_lost, bus.loss_count};
   endfunction

   task automatic test_reset();
      bus.locked = 1'b0; bus.clr_lost = 1'b0; rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_vec() !== 8'b1000_0000) begin
         $display("FAIL reset_values: got %b want %b", obs_vec(), 8'b1000_0000); n_err++;
      end
   endtask

   task automatic test_lock_sequence();
      int t_ready = 0, f12 = 0, f3 = 0;
      rst = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL seq_pre c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
      end
      bus.locked = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL seq_run c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ready && t_ready == 0) t_ready = c;
         if (bus.ce_12m && f12 == 0) f12 = c;
         if (bus.ce_3m && f3 == 0) begin
            f3 = c;
            n_cmp++;
            if (!(bus.ce_6m && bus.ce_12m)) begin
               $display("FAIL seq_align: ce_6m=%b ce_12m=%b want 1 1", bus.ce_6m, bus.ce_12m); n_err++;
            end
         end
      end
      n_cmp++;
      if (t_ready != LAT) begin
         $display("FAIL seq_latency: got %0d want %0d", t_ready, LAT); n_err++;
      end
      n_cmp++;
      if (f12 - t_ready != 3 || f3 - t_ready != 15) begin
         $display("FAIL seq_first_ce: ce12 at +%0d ce3 at +%0d want +3 +15", f12 - t_ready, f3 - t_ready);
         n_err++;
      end
   endtask

   task automatic test_run_drop();
      int first_sr = 0, t_ready = 0;
      bus.locked = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL drop c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.sys_reset && first_sr == 0) first_sr = c;
      end
      n_cmp++;
      if (first_sr < 1 || first_sr > SS + 1 || bus.ce_12m || bus.ready) begin
         $display("FAIL drop_reassert: first sys_reset at %0d ready=%b want <= %0d ready=0",
                  first_sr, bus.ready, SS + 1); n_err++;
      end
      n_cmp++;
      if (bus.lock_lost !== 1'b1 || bus.loss_count !== CW'(1)) begin
         $display("FAIL drop_loss: got lost=%b count=%0d want 1 1", bus.lock_lost, bus.loss_count); n_err++;
      end
      bus.locked = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL drop_reseq c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ready && t_ready == 0) t_ready = c;
      end
      n_cmp++;
      if (t_ready != LAT) begin
         $display("FAIL drop_relatency: got %0d want %0d", t_ready, LAT); n_err++;
      end
   endtask

   task automatic test_stabilize_drop();
      int t_ready = 0;
      logic saw_ready = 1'b0;
      bus.locked = 1'b0;
      repeat (5) @(negedge clk);
      bus.locked = 1'b1;
      for (int i = 0; i < 40 && m_p != 4; i++) @(negedge clk);
      n_cmp++;
      if (m_p != 4) begin
         $display("FAIL stab_reach: timeout, progress %0d want 4", m_p); n_err++;
      end
      bus.locked = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL stab_drop c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ready) saw_ready = 1'b1;
      end
      n_cmp++;
      if (saw_ready || bus.loss_count !== CW'(3)) begin
         $display("FAIL stab_loss: ready_seen=%b count=%0d want 0 3", saw_ready, bus.loss_count); n_err++;
      end
      bus.locked = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL stab_reseq c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ready && t_ready == 0) t_ready = c;
      end
      n_cmp++;
      if (t_ready != LAT) begin
         $display("FAIL stab_restart: ready after %0d want %0d", t_ready, LAT); n_err++;
      end
   endtask

   task automatic test_saturation();
      bus.clr_lost = 1'b1;
      @(negedge clk);
      bus.clr_lost = 1'b0;
      n_cmp++;
      if (bus.lock_lost !== 1'b0 || bus.loss_count !== CW'(0)) begin
         $display("FAIL sat_clr0: got lost=%b count=%0d want 0 0", bus.lock_lost, bus.loss_count); n_err++;
      end
      for (int e = 0; e < 7; e++) begin
         bus.locked = 1'b0;
         repeat ((e < 5) ? $urandom_range(1, 4) : 2) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               $display("FAIL sat_lo e=%0d: got %b want %b", e, obs_vec(), exp_vec()); n_err++;
            end
         end
         bus.locked = 1'b1;
         repeat ((e < 5) ? $urandom_range(3, 8) : 4) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               $display("FAIL sat_hi e=%0d: got %b want %b", e, obs_vec(), exp_vec()); n_err++;
            end
         end
         if (e == 4) begin
            n_cmp++;
            if (bus.lock_lost !== 1'b1 || bus.loss_count !== CW'(CMAX)) begin
               $display("FAIL sat_limit: got lost=%b count=%0d want 1 %0d", bus.lock_lost, bus.loss_count, CMAX);
               n_err++;
            end
            bus.clr_lost = 1'b1;
            @(negedge clk);
            bus.clr_lost = 1'b0;
            n_cmp++;
            if (bus.lock_lost !== 1'b0 || bus.loss_count !== CW'(0)) begin
               $display("FAIL sat_clr: got lost=%b count=%0d want 0 0", bus.lock_lost, bus.loss_count); n_err++;
            end
         end
      end
      n_cmp++;
      if (bus.loss_count !== CW'(2)) begin
         $display("FAIL sat_recount: got %0d want 2", bus.loss_count); n_err++;
      end
      bus.locked = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.clr_lost = 1'b1;
      @(negedge clk);
      bus.clr_lost = 1'b0;
      n_cmp++;
      if (bus.lock_lost !== 1'b1 || bus.loss_count !== CW'(1)) begin
         $display("FAIL sat_clr_vs_loss: got lost=%b count=%0d want 1 1", bus.lock_lost, bus.loss_count); n_err++;
      end
      bus.locked = 1'b1;
   endtask

   task automatic test_async_rst();
      int t_ready = 0;
      for (int i = 0; i < 60 && m_p != FULL - 2; i++) @(negedge clk);
      n_cmp++;
      if (m_p != FULL - 2) begin
         $display("FAIL arst_reach: timeout, progress %0d want %0d", m_p, FULL - 2); n_err++;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (obs_vec() !== 8'b1000_0000) begin
         $display("FAIL arst_immediate: got %b want %b", obs_vec(), 8'b1000_0000); n_err++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL arst_reseq c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ready && t_ready == 0) t_ready = c;
      end
      n_cmp++;
      if (t_ready != LAT) begin
         $display("FAIL arst_latency: got %0d want %0d", t_ready, LAT); n_err++;
      end
   endtask

   task automatic test_strobes();
      int n12 = 0, n6 = 0, n3 = 0, l12 = -1, l6 = -1, l3 = -1;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            $display("FAIL strobe c=%0d: got %b want %b", c, obs_vec(), exp_vec()); n_err++;
         end
         if (bus.ce_12m) begin
            if (l12 >= 0) begin
               n_cmp++;
               if (c - l12 != 4) begin $display("FAIL gap_12m: got %0d want 4", c - l12); n_err++; end
            end
            l12 = c; n12++;
         end
         if (bus.ce_6m) begin
            if (l6 >= 0) begin
               n_cmp++;
               if (c - l6 != 8) begin $display("FAIL gap_6m: got %0d want 8", c - l6); n_err++; end
            end
            l6 = c; n6++;
         end
         if (bus.ce_3m) begin
            if (l3 >= 0) begin
               n_cmp++;
               if (c - l3 != 16) begin $display("FAIL gap_3m: got %0d want 16", c - l3); n_err++; end
            end
            l3 = c; n3++;
         end
      end
      n_cmp++;
      if (n12 != 16 || n6 != 8 || n3 != 4) begin
         $display("FAIL strobe_count: got %0d/%0d/%0d want 16/8/4", n12, n6, n3); n_err++;
      end
   endtask

   task automatic test_random();
      int cyc = 0;
      while (cyc < 1500) begin
         bus.locked = ~bus.locked;
         repeat (bus.locked ? $urandom_range(1, 45) : $urandom_range(1, 5)) begin
            bus.clr_lost = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               if (n_err < 20)
                  $display("FAIL random cyc=%0d: got %b want %b", cyc, obs_vec(), exp_vec());
               n_err++;
            end
         end
      end
      bus.clr_lost = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock_sequence();
      test_run_drop();
      test_stabilize_drop();
      test_saturation();
      test_async_rst();
      test_strobes();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
